// File: rtl/aes_key_unexpand_128_pkg.sv
// Shared AES key-schedule tables, state encoding and word helpers for the
// forward and reverse key-expansion stages.
package aes_key_unexpand_128_pkg;

    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned RND_W  = 4;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT_LAST = 2'd1,
        SUB       = 2'd2,
        STEP      = 2'd3
    } state_t;

    // Round key as four 32-bit words, w0 in the most significant position.
    typedef struct packed {
        logic [WORD_W-1:0] w0;
        logic [WORD_W-1:0] w1;
        logic [WORD_W-1:0] w2;
        logic [WORD_W-1:0] w3;
    } key_t;

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [WORD_W-1:0] sub_word_comb(input logic [WORD_W-1:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel byte S-box lookups on a 32-bit word, registered output.
module aes_sbox_word
    import aes_key_unexpand_128_pkg::*;
(
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iEn,
    input  logic [WORD_W-1:0] iWord,
    output logic [WORD_W-1:0] oWord
);

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            oWord <= '0;
        end else if (iEn) begin
            oWord <= {SBOX[iWord[31:24]], SBOX[iWord[23:16]], SBOX[iWord[15:8]], SBOX[iWord[7:0]]};
        end
    end

endmodule

// File: rtl/aes_key_unexpand_128.sv
// Reverse AES-128 key schedule: emits round keys NUM_ROUNDS down to 0 from
// the final round key, one key every two cycles after the first.
module aes_key_unexpand_128
    import aes_key_unexpand_128_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 10
)
(
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic             iAbort,
    input  logic [KEY_W-1:0] iLast_key,
    output logic             oKey_valid,
    output logic [KEY_W-1:0] oKey,
    output logic [RND_W-1:0] oRound,
    output logic             oBusy,
    output logic             oDone
);

    state_t            state, stateNxt;
    key_t              keyReg, keyNxt;
    logic [RND_W-1:0]  rnd, rndNxt, rndDec, rconIdx;
    logic [WORD_W-1:0] p1, p2, p3, p1Nxt, p2Nxt, p3Nxt;
    logic [WORD_W-1:0] d1, d2, d3, p0, sboxIn, sboxOut;
    logic              sboxEn;
    logic              keyValidNxt, busyNxt, doneNxt;
    logic [KEY_W-1:0]  keyOutNxt;
    logic [RND_W-1:0]  roundNxt;

    // Word differences of the current key give words 1..3 of the previous key.
    assign d1      = keyReg.w1 ^ keyReg.w0;
    assign d2      = keyReg.w2 ^ keyReg.w1;
    assign d3      = keyReg.w3 ^ keyReg.w2;
    assign sboxIn  = rot_word(d3);
    assign rndDec  = rnd - RND_W'(1);
    assign rconIdx = (rnd == '0) ? '0 : rndDec;

    aes_sbox_word uSbox (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iEn    (sboxEn),
        .iWord  (sboxIn),
        .oWord  (sboxOut)
    );

    // The S-box lookup is launched while the current key is on the output, so
    // the previous key can be registered straight onto oKey at the end of SUB.
    always_comb begin
        stateNxt    = state;
        keyNxt      = keyReg;
        rndNxt      = rnd;
        p1Nxt       = p1;
        p2Nxt       = p2;
        p3Nxt       = p3;
        sboxEn      = 1'b0;
        keyValidNxt = 1'b0;
        doneNxt     = 1'b0;
        busyNxt     = oBusy;
        keyOutNxt   = oKey;
        roundNxt    = oRound;
        p0          = keyReg.w0 ^ sboxOut ^ {RCON[rconIdx], 24'h0};

        case (state)
            IDLE: begin
                if (iStart && !iAbort) begin
                    keyNxt      = key_t'(iLast_key);
                    rndNxt      = RND_W'(NUM_ROUNDS);
                    keyOutNxt   = iLast_key;
                    roundNxt    = RND_W'(NUM_ROUNDS);
                    keyValidNxt = 1'b1;
                    busyNxt     = 1'b1;
                    stateNxt    = EMIT_LAST;
                end
            end
            EMIT_LAST: begin
                p1Nxt    = d1;
                p2Nxt    = d2;
                p3Nxt    = d3;
                sboxEn   = 1'b1;
                stateNxt = SUB;
            end
            SUB: begin
                keyNxt      = key_t'({p0, p1, p2, p3});
                keyOutNxt   = {p0, p1, p2, p3};
                roundNxt    = rndDec;
                rndNxt      = rndDec;
                keyValidNxt = 1'b1;
                doneNxt     = (rndDec == '0);
                stateNxt    = STEP;
            end
            STEP: begin
                if (rnd == '0) begin
                    busyNxt  = 1'b0;
                    stateNxt = IDLE;
                end else begin
                    p1Nxt    = d1;
                    p2Nxt    = d2;
                    p3Nxt    = d3;
                    sboxEn   = 1'b1;
                    stateNxt = SUB;
                end
            end
            default: stateNxt = IDLE;
        endcase

        // Abort drops the run without touching the held key/round outputs.
        if (iAbort && (state != IDLE)) begin
            stateNxt    = IDLE;
            keyNxt      = keyReg;
            rndNxt      = rnd;
            keyValidNxt = 1'b0;
            doneNxt     = 1'b0;
            busyNxt     = 1'b0;
            keyOutNxt   = oKey;
            roundNxt    = oRound;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state      <= IDLE;
            keyReg     <= '0;
            rnd        <= '0;
            p1         <= '0;
            p2         <= '0;
            p3         <= '0;
            oKey_valid <= 1'b0;
            oKey       <= '0;
            oRound     <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
        end else begin
            state      <= stateNxt;
            keyReg     <= keyNxt;
            rnd        <= rndNxt;
            p1         <= p1Nxt;
            p2         <= p2Nxt;
            p3         <= p3Nxt;
            oKey_valid <= keyValidNxt;
            oKey       <= keyOutNxt;
            oRound     <= roundNxt;
            oBusy      <= busyNxt;
            oDone      <= doneNxt;
        end
    end

endmodule

// File: tb/tb_aes_key_unexpand_128.sv
// Bench for the reverse key schedule: expected keys come from a forward
// FIPS-197 key expansion, replayed in reverse order.
module tb_aes_key_unexpand_128;
    import aes_key_unexpand_128_pkg::*;

    logic         iClk = 1'b0;
    logic         iRst_n;
    logic         iStart;
    logic         iAbort;
    logic [127:0] iLast_key;

    logic         v10, b10, d10, v1, b1, d1;
    logic [127:0] k10, k1;
    logic [3:0]   r10, r1;

    logic         sel1 = 1'b0;
    logic         obsValid, obsBusy, obsDone;
    logic [127:0] obsKey;
    logic [3:0]   obsRound;

    logic [127:0] expKeys [0:10];
    logic [127:0] obsKeys [0:10];

    int checks   = 0;
    int failures = 0;

    always #5 iClk = ~iClk;

    aes_key_unexpand_128 #(.NUM_ROUNDS(10)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iAbort(iAbort), .iLast_key(iLast_key),
        .oKey_valid(v10), .oKey(k10), .oRound(r10), .oBusy(b10), .oDone(d10)
    );

    aes_key_unexpand_128 #(.NUM_ROUNDS(1)) dut1 (
        .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iAbort(iAbort), .iLast_key(iLast_key),
        .oKey_valid(v1), .oKey(k1), .oRound(r1), .oBusy(b1), .oDone(d1)
    );

    assign obsValid = sel1 ? v1 : v10;
    assign obsBusy  = sel1 ? b1 : b10;
    assign obsDone  = sel1 ? d1 : d10;
    assign obsKey   = sel1 ? k1 : k10;
    assign obsRound = sel1 ? r1 : r10;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward FIPS-197 expansion of key0 for n rounds into expKeys[0..n].
    task automatic expand(input logic [127:0] key0, input int n);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key0[127-32*i -: 32];
        for (int i = 4; i < 4*(n+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word_comb({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= n; r++) expKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Start a run in the current cycle; injections are cycle offsets from the
    // start cycle (0 = none). Returns in the first idle cycle after the run.
    task automatic runKey(input logic [127:0] key0, input int n,
                          input int injStart, input int injAbort, input int injRst);
        logic [127:0] lastKey;
        logic [3:0]   lastRound;
        logic         expValid;
        int           pulses;
        expand(key0, n);
        sel1 = (n == 1);
        for (int r = 0; r <= 10; r++) obsKeys[r] = '0;
        iLast_key = expKeys[n];
        iStart    = 1'b1;
        tick();
        iStart    = 1'b0;
        iLast_key = {$urandom, $urandom, $urandom, $urandom};
        pulses    = 0;
        lastKey   = expKeys[n];
        lastRound = 4'(n);
        for (int c = 1; c <= 2*n + 2; c++) begin
            if (injRst > 0 && c == injRst + 1) begin
                check($sformatf("rst c%0d valid", c), 128'(obsValid), 128'(0));
                check($sformatf("rst c%0d busy", c),  128'(obsBusy),  128'(0));
                check($sformatf("rst c%0d done", c),  128'(obsDone),  128'(0));
                check($sformatf("rst c%0d key", c),   obsKey,         128'(0));
                check($sformatf("rst c%0d round", c), 128'(obsRound), 128'(0));
                break;
            end
            if (injAbort > 0 && c == injAbort + 1) begin
                check($sformatf("abort c%0d valid", c), 128'(obsValid), 128'(0));
                check($sformatf("abort c%0d busy", c),  128'(obsBusy),  128'(0));
                check($sformatf("abort c%0d done", c),  128'(obsDone),  128'(0));
                check($sformatf("abort c%0d key", c),   obsKey,         lastKey);
                break;
            end
            expValid = (c % 2 == 1) && (c <= 2*n + 1);
            if (expValid) begin
                lastRound = 4'(n - (c - 1) / 2);
                lastKey   = expKeys[lastRound];
            end
            check($sformatf("n%0d c%0d valid", n, c), 128'(obsValid), 128'(expValid));
            check($sformatf("n%0d c%0d busy", n, c),  128'(obsBusy),  128'(c <= 2*n + 1));
            check($sformatf("n%0d c%0d done", n, c),  128'(obsDone),  128'(c == 2*n + 1));
            check($sformatf("n%0d c%0d key", n, c),   obsKey,         lastKey);
            check($sformatf("n%0d c%0d round", n, c), 128'(obsRound), 128'(lastRound));
            if (obsValid) begin
                pulses++;
                if (obsRound <= 4'd10) obsKeys[obsRound] = obsKey;
            end
            if (c == 2*n + 2) begin
                check($sformatf("n%0d pulses", n), 128'(pulses), 128'(n + 1));
                break;
            end
            iStart = (c == injStart);
            iAbort = (c == injAbort);
            iRst_n = !(c == injRst);
            tick();
            iStart = 1'b0;
            iAbort = 1'b0;
            iRst_n = 1'b1;
        end
    endtask

    localparam logic [127:0] FIPS_K0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] FIPS_K9  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    initial begin
        logic [127:0] rk;
        iRst_n    = 1'b0;
        iStart    = 1'b0;
        iAbort    = 1'b0;
        iLast_key = '0;
        idle(2);
        for (int s = 0; s < 2; s++) begin
            sel1 = (s == 1);
            #0;
            check($sformatf("reset%0d valid", s), 128'(obsValid), 128'(0));
            check($sformatf("reset%0d busy", s),  128'(obsBusy),  128'(0));
            check($sformatf("reset%0d done", s),  128'(obsDone),  128'(0));
            check($sformatf("reset%0d key", s),   obsKey,         128'(0));
            check($sformatf("reset%0d round", s), 128'(obsRound), 128'(0));
        end
        iRst_n = 1'b1;
        idle(1);

        // Known-answer run, then back-to-back run with an ignored mid-run start.
        runKey(FIPS_K0, 10, 0, 0, 0);
        check("fips r10", obsKeys[10], FIPS_K10);
        check("fips r9",  obsKeys[9],  FIPS_K9);
        check("fips r1",  obsKeys[1],  FIPS_K1);
        check("fips r0",  obsKeys[0],  FIPS_K0);
        runKey(FIPS_K0, 10, 5, 0, 0);
        check("b2b r0", obsKeys[0], FIPS_K0);

        idle(2);
        runKey(FIPS_K0, 10, 0, 8, 0);
        idle(1);
        runKey(FIPS_K0, 10, 0, 0, 0);
        check("restart r0", obsKeys[0], FIPS_K0);

        idle(24);
        runKey(FIPS_K0, 10, 0, 0, 6);
        runKey(FIPS_K0, 10, 0, 0, 0);
        check("post-reset r0", obsKeys[0], FIPS_K0);

        idle(24);
        runKey(FIPS_K0, 1, 0, 0, 0);
        check("n1 r1", obsKeys[1], FIPS_K1);
        check("n1 r0", obsKeys[0], FIPS_K0);

        for (int i = 0; i < 8; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            idle(24);
            if (i % 2 == 0) runKey(rk, 10, int'($urandom_range(2, 20)), 0, 0);
            else            runKey(rk, 1, 0, 0, 0);
            check($sformatf("rand%0d r0", i), obsKeys[0], rk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
